// File: rtl/or_reduce_packetizer.sv
// Packet accumulator: ORs every word of a packet, counts its beats (saturating),
// and presents the result on a registered valid/ready port with backpressure.
module or_reduce_packetizer #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [W-1:0]     up_data,
    input  logic             up_last,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [W-1:0]     down_vec,
    output logic             down_or,
    output logic [CNT_W-1:0] down_beats,
    output logic             down_sat
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_reg,      state_next;
    logic [W-1:0]     acc_vec_reg,    acc_vec_next;
    logic [CNT_W-1:0] acc_beats_reg,  acc_beats_next;
    logic             acc_sat_reg,    acc_sat_next;
    logic             down_valid_reg, down_valid_next;
    logic [W-1:0]     down_vec_reg,   down_vec_next;
    logic [CNT_W-1:0] down_beats_reg, down_beats_next;
    logic             down_sat_reg,   down_sat_next;

    logic             accept;
    logic [W-1:0]     merged_vec;
    logic             at_max;
    logic [CNT_W-1:0] inc_beats;
    logic             inc_sat;

    assign up_ready   = (state_reg != HOLD);
    assign accept     = up_valid && up_ready;
    assign merged_vec = acc_vec_reg | up_data;
    assign at_max     = (acc_beats_reg == CNT_MAX);
    // Counter sticks at its maximum; one more beat past it marks saturation.
    assign inc_beats  = at_max ? acc_beats_reg : acc_beats_reg + CNT_ONE;
    assign inc_sat    = acc_sat_reg | at_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            acc_vec_reg    <= '0;
            acc_beats_reg  <= '0;
            acc_sat_reg    <= 1'b0;
            down_valid_reg <= 1'b0;
            down_vec_reg   <= '0;
            down_beats_reg <= '0;
            down_sat_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            acc_vec_reg    <= acc_vec_next;
            acc_beats_reg  <= acc_beats_next;
            acc_sat_reg    <= acc_sat_next;
            down_valid_reg <= down_valid_next;
            down_vec_reg   <= down_vec_next;
            down_beats_reg <= down_beats_next;
            down_sat_reg   <= down_sat_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        acc_vec_next    = acc_vec_reg;
        acc_beats_next  = acc_beats_reg;
        acc_sat_next    = acc_sat_reg;
        down_valid_next = down_valid_reg;
        down_vec_next   = down_vec_reg;
        down_beats_next = down_beats_reg;
        down_sat_next   = down_sat_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (up_last) begin
                        state_next      = HOLD;
                        down_valid_next = 1'b1;
                        down_vec_next   = up_data;
                        down_beats_next = CNT_ONE;
                        down_sat_next   = 1'b0;
                    end else begin
                        state_next     = ACCUM;
                        acc_vec_next   = up_data;
                        acc_beats_next = CNT_ONE;
                        acc_sat_next   = 1'b0;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (up_last) begin
                        state_next      = HOLD;
                        down_valid_next = 1'b1;
                        down_vec_next   = merged_vec;
                        down_beats_next = inc_beats;
                        down_sat_next   = inc_sat;
                        acc_vec_next    = '0;
                        acc_beats_next  = '0;
                        acc_sat_next    = 1'b0;
                    end else begin
                        acc_vec_next   = merged_vec;
                        acc_beats_next = inc_beats;
                        acc_sat_next   = inc_sat;
                    end
                end
            end
            HOLD: begin
                // Result data stays put after handoff; only valid drops.
                if (down_ready) begin
                    state_next      = IDLE;
                    down_valid_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign down_valid = down_valid_reg;
    assign down_vec   = down_vec_reg;
    assign down_or    = |down_vec_reg;
    assign down_beats = down_beats_reg;
    assign down_sat   = down_sat_reg;

endmodule

// File: tb/tb_or_reduce_packetizer.sv
// Bench for or_reduce_packetizer (W=8, CNT_W=2): vector table, directed corner
// sequences, and a randomized stream scored against a packet-level model.
module tb_or_reduce_packetizer;

    localparam int W     = 8;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             up_valid = 1'b0;
    logic             up_ready;
    logic [W-1:0]     up_data = '0;
    logic             up_last = 1'b0;
    logic             down_valid;
    logic             down_ready = 1'b0;
    logic [W-1:0]     down_vec;
    logic             down_or;
    logic [CNT_W-1:0] down_beats;
    logic             down_sat;

    int checks = 0;
    int errors = 0;

    or_reduce_packetizer #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_last(up_last),
        .down_valid(down_valid), .down_ready(down_ready), .down_vec(down_vec),
        .down_or(down_or), .down_beats(down_beats), .down_sat(down_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [47:0] words;
        logic [7:0]  vec;
        logic        orr;
        logic [1:0]  beats;
        logic        sat;
    } vec_t;

    typedef struct {
        logic [7:0] vec;
        logic [1:0] beats;
        logic       sat;
    } res_t;

    vec_t tbl[7];
    res_t exp_q[$];
    bit   drv_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one word and keep it until the block takes it.
    task automatic put_word(input logic [7:0] d, input logic last);
        bit took = 0;
        up_valid = 1'b1;
        up_data  = d;
        up_last  = last;
        for (int k = 0; k < 1000; k++) begin
            took = up_ready;
            @(posedge clk);
            #1;
            if (took) break;
        end
        up_valid = 1'b0;
        if (!took) begin
            checks++;
            errors++;
            $display("FAIL put_word: up_ready never asserted");
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_result(input string name, input logic [7:0] v, input logic o,
                              input logic [1:0] b, input logic s);
        chk({name, "_valid"}, down_valid, 1);
        chk({name, "_vec"}, down_vec, v);
        chk({name, "_or"}, down_or, o);
        chk({name, "_beats"}, down_beats, b);
        chk({name, "_sat"}, down_sat, s);
        chk({name, "_upready"}, up_ready, 0);
    endtask

    task automatic handoff(input string name);
        down_ready = 1'b1;
        @(posedge clk);
        #1;
        down_ready = 1'b0;
        chk({name, "_valid_drop"}, down_valid, 0);
        chk({name, "_upready_back"}, up_ready, 1);
    endtask

    initial begin
        tbl[0] = '{1, 48'h0000_0000_00AA, 8'hAA, 1'b1, 2'd1, 1'b0};
        tbl[1] = '{2, 48'h0000_0000_F00F, 8'hFF, 1'b1, 2'd2, 1'b0};
        tbl[2] = '{3, 48'h0000_0000_0000, 8'h00, 1'b0, 2'd3, 1'b0};
        tbl[3] = '{4, 48'h0000_0804_0201, 8'h0F, 1'b1, 2'd3, 1'b1};
        tbl[4] = '{5, 48'h0000_0000_0000, 8'h00, 1'b0, 2'd3, 1'b1};
        tbl[5] = '{2, 48'h0000_0000_0000, 8'h00, 1'b0, 2'd2, 1'b0};
        tbl[6] = '{6, 48'h0408_1020_4080, 8'hFC, 1'b1, 2'd3, 1'b1};

        // Reset state, including up_ready=1 while held in reset
        #12;
        chk("rst_upready", up_ready, 1);
        chk("rst_valid", down_valid, 0);
        chk("rst_vec", down_vec, 0);
        chk("rst_or", down_or, 0);
        chk("rst_beats", down_beats, 0);
        chk("rst_sat", down_sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-beat zero packet, downstream ready
        down_ready = 1'b1;
        put_word(8'h00, 1'b1);
        chk("single_valid", down_valid, 1);
        chk("single_vec", down_vec, 8'h00);
        chk("single_or", down_or, 0);
        chk("single_beats", down_beats, 1);
        chk("single_sat", down_sat, 0);
        @(posedge clk);
        #1;
        down_ready = 1'b0;
        chk("single_valid_drop", down_valid, 0);
        chk("single_upready", up_ready, 1);

        // Three beats with an idle gap, then 5 cycles of backpressure
        put_word(8'h01, 1'b0);
        idle(1);
        put_word(8'h10, 1'b0);
        put_word(8'h80, 1'b1);
        chk_result("three", 8'h91, 1'b1, 2'd3, 1'b0);
        for (int k = 0; k < 5; k++) begin
            up_valid = 1'b1;
            up_data  = 8'h55;
            up_last  = 1'b1;
            @(posedge clk);
            #1;
            chk_result("bp", 8'h91, 1'b1, 2'd3, 1'b0);
        end
        up_valid = 1'b0;
        handoff("bp");

        // Table of packets
        for (int i = 0; i < 7; i++) begin
            for (int b = 0; b < tbl[i].n; b++)
                put_word(tbl[i].words[8*b +: 8], (b == tbl[i].n - 1));
            chk_result($sformatf("tbl%0d", i), tbl[i].vec, tbl[i].orr, tbl[i].beats, tbl[i].sat);
            handoff($sformatf("tbl%0d", i));
        end

        // Asynchronous reset in the middle of a packet
        put_word(8'hFF, 1'b0);
        put_word(8'hFF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vec", down_vec, 0);
        chk("arst_beats", down_beats, 0);
        chk("arst_sat", down_sat, 0);
        chk("arst_valid", down_valid, 0);
        chk("arst_upready", up_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        put_word(8'h02, 1'b1);
        chk_result("post_rst", 8'h02, 1'b1, 2'd1, 1'b0);
        handoff("post_rst");

        // Randomized stream against the packet-level model
        fork
            begin
                for (int p = 0; p < 1000; p++) begin
                    int   n;
                    logic [7:0] words[6];
                    res_t r;
                    n = $urandom_range(1, 6);
                    r.vec = 8'h00;
                    for (int b = 0; b < n; b++) begin
                        case ($urandom_range(0, 3))
                            0: words[b] = 8'h00;
                            1: words[b] = 8'h01 << $urandom_range(0, 7);
                            default: words[b] = 8'($urandom);
                        endcase
                        r.vec = r.vec | words[b];
                    end
                    r.beats = (n > CMAX) ? 2'(CMAX) : 2'(n);
                    r.sat   = (n > CMAX);
                    exp_q.push_back(r);
                    for (int b = 0; b < n; b++) begin
                        put_word(words[b], (b == n - 1));
                        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    end
                end
                drv_done = 1;
            end
            begin
                int         cyc = 0;
                int         got = 0;
                bit         stall = 0;
                logic [10:0] prev = '0;
                while (!(drv_done && exp_q.size() == 0) && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    if (stall) begin
                        chk("rnd_stall_valid", down_valid, 1);
                        chk("rnd_stable", {down_sat, down_beats, down_vec}, prev);
                    end
                    chk("rnd_upready", up_ready, !down_valid);
                    down_ready = $urandom_range(0, 1);
                    if (down_valid && down_ready) begin
                        stall = 0;
                        got++;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rnd_extra: unexpected result vec=%0h beats=%0d", down_vec, down_beats);
                        end else begin
                            res_t r;
                            r = exp_q.pop_front();
                            chk("rnd_vec", down_vec, r.vec);
                            chk("rnd_or", down_or, |r.vec);
                            chk("rnd_beats", down_beats, r.beats);
                            chk("rnd_sat", down_sat, r.sat);
                        end
                    end else begin
                        stall = down_valid;
                        prev  = {down_sat, down_beats, down_vec};
                    end
                end
                down_ready = 1'b0;
                chk("rnd_drain", exp_q.size(), 0);
                chk("rnd_count", got, 1000);
            end
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
